regfile_wb_scheduler: RTL and testbench

- Schedules the single register-file write port between the in-order writeback stage and the multi-cycle multiply/accumulate unit.
- Queues completed MUL results and drains them into free write-port cycles.
- Keeps a 32-entry scoreboard of registers with outstanding MUL results.
- Drives Stall to the decode stage on RAW or WAW hazards against those registers.

---
 rtl/regfile_wb_scheduler.sv | 123 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates pipe writeback vs. queued MUL results
// and keeps a scoreboard of registers awaiting MUL results for decode stalls.
module regfile_wb_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       PipeWrEn,
  input  logic [4:0]                 PipeWrAddr,
  input  logic [31:0]                PipeWrData,
  input  logic                       MulIssue,
  input  logic [4:0]                 MulIssueAddr,
  input  logic                       MulDone,
  input  logic [4:0]                 MulDoneAddr,
  input  logic [31:0]                MulDoneData,
  output logic                       MulDoneReady,
  input  logic [4:0]                 RsAddr,
  input  logic [4:0]                 RtAddr,
  output logic                       Stall,
  output logic                       RegWrite,
  output logic [4:0]                 RAddr,
  output logic [31:0]                RData,
  output logic [31:0]                Pending,
  output logic [$clog2(DEPTH+1)-1:0] QCount
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [4:0]    qaddr_q [DEPTH];
  logic [4:0]    qaddr_d [DEPTH];
  logic [31:0]   qdata_q [DEPTH];
  logic [31:0]   qdata_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pending_q, pending_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    raddr_q, raddr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          src_mul_q, src_mul_d;
  logic          push, pop, issue_set;

  assign MulDoneReady = (count_q != FULL_C);
  assign QCount       = count_q;
  assign Pending      = pending_q;
  assign RegWrite     = reg_write_q;
  assign RAddr        = raddr_q;
  assign RData        = rdata_q;

  assign Stall = ((RsAddr != 5'd0) && pending_q[RsAddr]) ||
                 ((RtAddr != 5'd0) && pending_q[RtAddr]) ||
                 (MulIssue && pending_q[MulIssueAddr]);

  always_comb begin
    push        = MulDone && MulDoneReady;
    pop         = !PipeWrEn && (count_q != '0);
    issue_set   = MulIssue && !Stall && (MulIssueAddr != 5'd0);
    qaddr_d     = qaddr_q;
    qdata_d     = qdata_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    pending_d   = pending_q;
    reg_write_d = 1'b0;
    raddr_d     = raddr_q;
    rdata_d     = rdata_q;
    src_mul_d   = 1'b0;

    if (push) begin
      qaddr_d[wr_ptr_q] = MulDoneAddr;
      qdata_d[wr_ptr_q] = MulDoneData;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end

    if (PipeWrEn) begin
      reg_write_d = (PipeWrAddr != 5'd0);
      raddr_d     = PipeWrAddr;
      rdata_d     = PipeWrData;
    end else if (pop) begin
      reg_write_d = (qaddr_q[rd_ptr_q] != 5'd0);
      raddr_d     = qaddr_q[rd_ptr_q];
      rdata_d     = qdata_q[rd_ptr_q];
      src_mul_d   = 1'b1;
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end

    // Clear lands on the same edge the register file commits the MUL value; set wins.
    if (reg_write_q && src_mul_q) pending_d[raddr_q] = 1'b0;
    if (issue_set) pending_d[MulIssueAddr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pending_q   <= '0;
      reg_write_q <= 1'b0;
      raddr_q     <= '0;
      rdata_q     <= '0;
      src_mul_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      reg_write_q <= reg_write_d;
      raddr_q     <= raddr_d;
      rdata_q     <= rdata_d;
      src_mul_q   <= src_mul_d;
    end
  end

  // Queue storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge Clock) begin
    qaddr_q <= qaddr_d;
    qdata_q <= qdata_d;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: a queue-based reference model predicts
// each cycle's write-port output; a monitor pops and compares after every edge.
module tb_regfile_wb_scheduler;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          Clock = 1'b0;
  logic          Reset, PipeWrEn, MulIssue, MulDone;
  logic [4:0]    PipeWrAddr, MulIssueAddr, MulDoneAddr, RsAddr, RtAddr;
  logic [31:0]   PipeWrData, MulDoneData;
  logic          MulDoneReady, Stall, RegWrite;
  logic [4:0]    RAddr;
  logic [31:0]   RData, Pending;
  logic [CW-1:0] QCount;

  regfile_wb_scheduler #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .PipeWrEn(PipeWrEn), .PipeWrAddr(PipeWrAddr), .PipeWrData(PipeWrData),
    .MulIssue(MulIssue), .MulIssueAddr(MulIssueAddr),
    .MulDone(MulDone), .MulDoneAddr(MulDoneAddr), .MulDoneData(MulDoneData),
    .MulDoneReady(MulDoneReady), .RsAddr(RsAddr), .RtAddr(RtAddr), .Stall(Stall),
    .RegWrite(RegWrite), .RAddr(RAddr), .RData(RData), .Pending(Pending), .QCount(QCount)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  typedef struct { logic we; logic [4:0] a; logic [31:0] d; } exp_t;

  int checks = 0;
  int failures = 0;

  // Reference model state
  ent_t       mq[$];
  exp_t       scb[$];
  bit         pend[32];
  logic [4:0] m_addr;
  logic [31:0] m_data;
  bit         m_mulwrite;
  bit         m_valid = 0;

  // Stimulus staging
  logic        i_rst, i_pwe, i_mi, i_md;
  logic [4:0]  i_paddr, i_miaddr, i_mdaddr, i_rs, i_rt;
  logic [31:0] i_pdata, i_mddata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    i_rst = 0; i_pwe = 0; i_mi = 0; i_md = 0;
    i_paddr = 0; i_miaddr = 0; i_mdaddr = 0; i_rs = 0; i_rt = 0;
    i_pdata = 0; i_mddata = 0;
  endtask

  task automatic tick();
    bit stall_e, ready_e;
    logic [31:0] pv;
    exp_t e;
    ent_t h;
    ent_t n;
    @(negedge Clock);
    Reset = i_rst; PipeWrEn = i_pwe; PipeWrAddr = i_paddr; PipeWrData = i_pdata;
    MulIssue = i_mi; MulIssueAddr = i_miaddr; MulDone = i_md; MulDoneAddr = i_mdaddr;
    MulDoneData = i_mddata; RsAddr = i_rs; RtAddr = i_rt;
    #1;
    stall_e = (i_rs != 0 && pend[i_rs]) || (i_rt != 0 && pend[i_rt]) || (i_mi && pend[i_miaddr]);
    ready_e = (mq.size() < DEPTH);
    if (m_valid) begin
      pv = '0;
      for (int k = 0; k < 32; k++) pv[k] = pend[k];
      chk("stall", {31'd0, Stall}, {31'd0, stall_e});
      chk("ready", {31'd0, MulDoneReady}, {31'd0, ready_e});
      chk("qcount", {{(32-CW){1'b0}}, QCount}, mq.size());
      chk("pending", Pending, pv);
    end
    if (i_rst) begin
      mq.delete();
      for (int k = 0; k < 32; k++) pend[k] = 0;
      m_addr = 0; m_data = 0; m_mulwrite = 0;
      e.we = 0; e.a = 0; e.d = 0;
      m_valid = 1;
    end else begin
      if (m_mulwrite) pend[m_addr] = 0;
      if (i_mi && !stall_e && i_miaddr != 0) pend[i_miaddr] = 1;
      m_mulwrite = 0;
      e.we = 0;
      if (i_pwe) begin
        e.we = (i_paddr != 0); m_addr = i_paddr; m_data = i_pdata;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        e.we = (h.a != 0); m_addr = h.a; m_data = h.d; m_mulwrite = e.we;
      end
      e.a = m_addr; e.d = m_data;
      if (i_md && ready_e) begin
        n.a = i_mdaddr; n.d = i_mddata;
        mq.push_back(n);
      end
    end
    scb.push_back(e);
  endtask

  // Monitor: every edge produces one write-port observation to match.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        chk("regwrite", {31'd0, RegWrite}, {31'd0, e.we});
        chk("raddr", {27'd0, RAddr}, {27'd0, e.a});
        chk("rdata", RData, e.d);
      end
    end
  end

  initial begin
    idle_in();
    i_rst = 1; tick(); tick();
    idle_in(); tick(); tick();

    // RAW stall then MUL completion clears it
    i_mi = 1; i_miaddr = 5; tick();
    idle_in(); i_rs = 5; tick();
    i_md = 1; i_mdaddr = 5; i_mddata = 32'hDEADBEEF; tick();
    i_md = 0; tick(); tick(); tick();

    // Pipe holds the port while a result waits
    idle_in(); i_pwe = 1; i_paddr = 3; i_pdata = 32'h11;
    i_md = 1; i_mdaddr = 7; i_mddata = 32'h77; tick();
    i_md = 0; tick(); tick();
    i_pwe = 0; tick(); tick();

    // Fill to DEPTH, fifth result ignored, then drain in order
    idle_in(); i_pwe = 1; i_paddr = 2; i_pdata = 32'h22;
    for (int k = 0; k < 5; k++) begin
      i_md = 1; i_mdaddr = 5'(10 + k); i_mddata = $urandom; tick();
    end
    idle_in(); for (int k = 0; k < 6; k++) tick();

    // WAW stall and register-0 writes
    i_mi = 1; i_miaddr = 9; tick();
    tick();
    idle_in(); i_pwe = 1; i_paddr = 0; i_pdata = 32'h99; tick();
    idle_in(); i_md = 1; i_mdaddr = 0; i_mddata = 32'h5; tick();
    i_mdaddr = 9; i_mddata = 32'h9; tick();
    idle_in(); tick(); tick(); tick();

    // Reset with a partly full queue and pending bits
    i_mi = 1; i_miaddr = 12; i_pwe = 1; i_paddr = 4; i_pdata = 32'h4;
    for (int k = 0; k < 3; k++) begin
      i_md = 1; i_mdaddr = 5'(20 + k); i_mddata = $urandom; tick();
      i_mi = 0;
    end
    idle_in(); i_rst = 1; tick();
    idle_in(); tick(); tick();

    // Random traffic over a small address range so hazards collide often
    for (int c = 0; c < 3000; c++) begin
      i_rst    = ($urandom_range(0, 199) == 0);
      i_pwe    = ($urandom_range(0, 2) == 0);
      i_paddr  = 5'($urandom_range(0, 7));
      i_pdata  = $urandom;
      i_mi     = ($urandom_range(0, 3) == 0);
      i_miaddr = 5'($urandom_range(0, 7));
      i_md     = ($urandom_range(0, 1) == 0);
      i_mdaddr = 5'($urandom_range(0, 7));
      i_mddata = $urandom;
      i_rs     = 5'($urandom_range(0, 7));
      i_rt     = 5'($urandom_range(0, 7));
      tick();
    end
    idle_in(); for (int k = 0; k < 8; k++) tick();

    @(negedge Clock); @(negedge Clock); #2;
    chk("scb_drained", scb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
